fft_twiddle_mult_pipe: RTL and testbench

Parametrised streaming twiddle-multiply stage for the radix-4 FFT datapath. It sits between a butterfly stage and the next stage's input.
- Lane 0 passes through a delay line matched to the multiplier pipeline.
- Lanes 1..LANES-1 are each multiplied by their own complex twiddle, with selectable rounding and saturation.
- Adds a valid/ready handshake with stall, a global bypass mode, a frame-end sideband and a sticky overflow flag.

---
 rtl/fft_twiddle_mult_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_fft_twiddle_mult_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_mult_pipe.sv
// fft_twiddle_mult_pipe
// Streaming twiddle-multiply stage for the radix-4 FFT datapath.
// Lane 0 is delayed to match the multiplier; lanes 1..LANES-1 are rotated by
// their own complex twiddle with optional round-half-up and saturation.
// Three register stages (capture, products, sum/scale) sit behind a
// valid/ready handshake in which every stage holds whenever the output is
// stalled, so all lanes and the sideband stay aligned.

module fft_twiddle_mult_pipe #(
    parameter int D_BIT = 17,
    parameter int W_BIT = 12,
    parameter int LANES = 4,
    parameter int RND   = 1,
    parameter int SAT   = 1
) (
    input  logic                       iCLK,
    input  logic                       iRESET,
    input  logic                       iVALID,
    output logic                       oREADY,
    input  logic                       iLAST,
    input  logic                       iBYPASS,
    input  logic [LANES*D_BIT-1:0]     iX_RE,
    input  logic [LANES*D_BIT-1:0]     iX_IM,
    input  logic [(LANES-1)*W_BIT-1:0] iW_RE,
    input  logic [(LANES-1)*W_BIT-1:0] iW_IM,
    input  logic                       iREADY,
    output logic                       oVALID,
    output logic                       oLAST,
    output logic [LANES*D_BIT-1:0]     oY_RE,
    output logic [LANES*D_BIT-1:0]     oY_IM,
    output logic                       oSAT,
    input  logic                       iCLR_SAT
);

    // Twiddle 1.0 is 2^SH; products carry SH fractional bits.
    localparam int SH = W_BIT - 2;
    localparam int PW = D_BIT + W_BIT;      // single product width
    localparam int SW = PW + 1;             // sum/difference of two products
    localparam int XW = LANES * D_BIT;
    localparam int TW = (LANES - 1) * W_BIT;

    localparam logic signed [SW-1:0] MAX_V = SW'((64'sd1 <<< (D_BIT - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;
    localparam logic signed [SW-1:0] RND_C = SW'(64'sd1 <<< (SH - 1));

    // Signed D_BIT x W_BIT multiply, both operands sign-extended to the full product width.
    function automatic logic signed [PW-1:0] cmul(input logic [D_BIT-1:0] a,
                                                  input logic [W_BIT-1:0] b);
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        ae = {{W_BIT{a[D_BIT-1]}}, a};
        be = {{D_BIT{b[W_BIT-1]}}, b};
        cmul = ae * be;
    endfunction

    // Round, drop the fractional bits and clamp/wrap; returns {saturated, value}.
    function automatic logic [D_BIT:0] scale(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        logic                 sat_f;
        logic [D_BIT-1:0]     v;
        if (RND != 0) begin
            r = s + RND_C;
        end else begin
            r = s;
        end
        r     = r >>> SH;
        sat_f = 1'b0;
        if (SAT != 0) begin
            if (r > MAX_V) begin
                v     = MAX_V[D_BIT-1:0];
                sat_f = 1'b1;
            end else if (r < MIN_V) begin
                v     = MIN_V[D_BIT-1:0];
                sat_f = 1'b1;
            end else begin
                v = r[D_BIT-1:0];
            end
        end else begin
            v = r[D_BIT-1:0];
        end
        scale = {sat_f, v};
    endfunction

    logic advance_s;

    logic              s1_valid_r;
    logic              s1_last_r;
    logic              s1_byp_r;
    logic [XW-1:0]     s1_xre_r;
    logic [XW-1:0]     s1_xim_r;
    logic [TW-1:0]     s1_wre_r;
    logic [TW-1:0]     s1_wim_r;

    logic              s2_valid_r;
    logic              s2_last_r;
    logic              s2_byp_r;
    logic [XW-1:0]     s2_xre_r;
    logic [XW-1:0]     s2_xim_r;
    logic signed [PW-1:0] s2_prr_r [1:LANES-1];
    logic signed [PW-1:0] s2_pii_r [1:LANES-1];
    logic signed [PW-1:0] s2_pri_r [1:LANES-1];
    logic signed [PW-1:0] s2_pir_r [1:LANES-1];

    logic signed [SW-1:0] re_sum_s [1:LANES-1];
    logic signed [SW-1:0] im_sum_s [1:LANES-1];
    logic [D_BIT:0]       re_sc_s  [1:LANES-1];
    logic [D_BIT:0]       im_sc_s  [1:LANES-1];
    logic [XW-1:0]        y_re_s;
    logic [XW-1:0]        y_im_s;
    logic                 sat_any_s;

    // The pipeline moves when the output slot is empty or being consumed.
    always_comb begin
        advance_s = iREADY | ~oVALID;
    end

    assign oREADY = advance_s;

    // Stage 1: capture the input beat (a bubble is captured as an invalid stage).
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_byp_r   <= 1'b0;
            s1_xre_r   <= {XW{1'b0}};
            s1_xim_r   <= {XW{1'b0}};
            s1_wre_r   <= {TW{1'b0}};
            s1_wim_r   <= {TW{1'b0}};
        end else if (advance_s) begin
            s1_valid_r <= iVALID;
            s1_last_r  <= iLAST;
            s1_byp_r   <= iBYPASS;
            s1_xre_r   <= iX_RE;
            s1_xim_r   <= iX_IM;
            s1_wre_r   <= iW_RE;
            s1_wim_r   <= iW_IM;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: register the four partial products of each multiplied lane; carry X along for lane 0/bypass.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_byp_r   <= 1'b0;
            s2_xre_r   <= {XW{1'b0}};
            s2_xim_r   <= {XW{1'b0}};
            for (int k = 1; k < LANES; k++) begin
                s2_prr_r[k] <= {PW{1'b0}};
                s2_pii_r[k] <= {PW{1'b0}};
                s2_pri_r[k] <= {PW{1'b0}};
                s2_pir_r[k] <= {PW{1'b0}};
            end
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
            s2_byp_r   <= s1_byp_r;
            s2_xre_r   <= s1_xre_r;
            s2_xim_r   <= s1_xim_r;
            for (int k = 1; k < LANES; k++) begin
                s2_prr_r[k] <= cmul(s1_xre_r[k*D_BIT +: D_BIT], s1_wre_r[(k-1)*W_BIT +: W_BIT]);
                s2_pii_r[k] <= cmul(s1_xim_r[k*D_BIT +: D_BIT], s1_wim_r[(k-1)*W_BIT +: W_BIT]);
                s2_pri_r[k] <= cmul(s1_xre_r[k*D_BIT +: D_BIT], s1_wim_r[(k-1)*W_BIT +: W_BIT]);
                s2_pir_r[k] <= cmul(s1_xim_r[k*D_BIT +: D_BIT], s1_wre_r[(k-1)*W_BIT +: W_BIT]);
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Stage 3 datapath: combine products, scale each lane, and pass lane 0 / bypassed beats through.
    always_comb begin
        y_re_s    = s2_xre_r;
        y_im_s    = s2_xim_r;
        sat_any_s = 1'b0;
        for (int k = 1; k < LANES; k++) begin
            re_sum_s[k] = {s2_prr_r[k][PW-1], s2_prr_r[k]} - {s2_pii_r[k][PW-1], s2_pii_r[k]};
            im_sum_s[k] = {s2_pri_r[k][PW-1], s2_pri_r[k]} + {s2_pir_r[k][PW-1], s2_pir_r[k]};
            re_sc_s[k]  = scale(re_sum_s[k]);
            im_sc_s[k]  = scale(im_sum_s[k]);
            if (!s2_byp_r) begin
                y_re_s[k*D_BIT +: D_BIT] = re_sc_s[k][D_BIT-1:0];
                y_im_s[k*D_BIT +: D_BIT] = im_sc_s[k][D_BIT-1:0];
                sat_any_s = sat_any_s | re_sc_s[k][D_BIT] | im_sc_s[k][D_BIT];
            end else begin
                y_re_s[k*D_BIT +: D_BIT] = s2_xre_r[k*D_BIT +: D_BIT];
                y_im_s[k*D_BIT +: D_BIT] = s2_xim_r[k*D_BIT +: D_BIT];
            end
        end
    end

    // Stage 3 registers: output beat, valid and frame-end sideband.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oVALID <= 1'b0;
            oLAST  <= 1'b0;
            oY_RE  <= {XW{1'b0}};
            oY_IM  <= {XW{1'b0}};
        end else if (advance_s) begin
            oVALID <= s2_valid_r;
            oLAST  <= s2_last_r;
            oY_RE  <= y_re_s;
            oY_IM  <= y_im_s;
        end else begin
            oVALID <= oVALID;
        end
    end

    // Sticky saturation flag: a valid saturating beat entering the output wins over a clear.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oSAT <= 1'b0;
        end else if (advance_s && s2_valid_r && sat_any_s) begin
            oSAT <= 1'b1;
        end else if (iCLR_SAT) begin
            oSAT <= 1'b0;
        end else begin
            oSAT <= oSAT;
        end
    end

endmodule

// File: tb/tb_fft_twiddle_mult_pipe.sv
// Directed bench for fft_twiddle_mult_pipe. Two instances share the stimulus:
// "a" uses round-half-up with saturation, "b" uses truncation with wrap.
module tb_fft_twiddle_mult_pipe;

    localparam int D = 17;
    localparam int W = 12;
    localparam int L = 4;

    logic             iCLK = 1'b0;
    logic             iRESET;
    logic             iVALID;
    logic             iLAST;
    logic             iBYPASS;
    logic             iREADY;
    logic             iCLR_SAT;
    logic [L*D-1:0]   iX_RE;
    logic [L*D-1:0]   iX_IM;
    logic [(L-1)*W-1:0] iW_RE;
    logic [(L-1)*W-1:0] iW_IM;

    logic             a_oREADY, a_oVALID, a_oLAST, a_oSAT;
    logic [L*D-1:0]   a_oY_RE, a_oY_IM;
    logic             b_oREADY, b_oVALID, b_oLAST, b_oSAT;
    logic [L*D-1:0]   b_oY_RE, b_oY_IM;

    int n_chk  = 0;
    int n_fail = 0;

    fft_twiddle_mult_pipe #(.D_BIT(D), .W_BIT(W), .LANES(L), .RND(1), .SAT(1)) u_a (
        .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .oREADY(a_oREADY),
        .iLAST(iLAST), .iBYPASS(iBYPASS), .iX_RE(iX_RE), .iX_IM(iX_IM),
        .iW_RE(iW_RE), .iW_IM(iW_IM), .iREADY(iREADY), .oVALID(a_oVALID),
        .oLAST(a_oLAST), .oY_RE(a_oY_RE), .oY_IM(a_oY_IM), .oSAT(a_oSAT),
        .iCLR_SAT(iCLR_SAT)
    );

    fft_twiddle_mult_pipe #(.D_BIT(D), .W_BIT(W), .LANES(L), .RND(0), .SAT(0)) u_b (
        .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .oREADY(b_oREADY),
        .iLAST(iLAST), .iBYPASS(iBYPASS), .iX_RE(iX_RE), .iX_IM(iX_IM),
        .iW_RE(iW_RE), .iW_IM(iW_IM), .iREADY(iREADY), .oVALID(b_oVALID),
        .oLAST(b_oLAST), .oY_RE(b_oY_RE), .oY_IM(b_oY_IM), .oSAT(b_oSAT),
        .iCLR_SAT(iCLR_SAT)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [31:0] lane(input logic [L*D-1:0] v, input int k);
        logic [D-1:0] t;
        t = v[k*D +: D];
        return {{(32-D){t[D-1]}}, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #2;
    endtask

    task automatic set_lane(input int k, input int xr, input int xi, input int wr, input int wi);
        iX_RE[k*D +: D] = xr[D-1:0];
        iX_IM[k*D +: D] = xi[D-1:0];
        if (k > 0) begin
            iW_RE[(k-1)*W +: W] = wr[W-1:0];
            iW_IM[(k-1)*W +: W] = wi[W-1:0];
        end
    endtask

    // One beat accepted at the next edge; returns after the third edge.
    task automatic send_one();
        iVALID = 1'b1;
        tick();
        iVALID = 1'b0;
        tick();
        chk("lat_not_early", a_oVALID, 1'b0);
        tick();
        chk("lat_3", a_oVALID, 1'b1);
    endtask

    // Stream data: mode 0 counting data with twiddle 1.0, mode 1 twiddle j with alternate bypass.
    function automatic int sx(input int mode, input int b, input int k, input int im);
        if (mode == 0) return (im != 0) ? -(b*16 + k) : (b*16 + k);
        return (im != 0) ? -(50*b + k + 3) : (100*b + 10*k + 1);
    endfunction

    function automatic int ey(input int mode, input int b, input int k, input int im);
        if (mode == 0 || k == 0 || (b % 2) == 0) return sx(mode, b, k, im);
        return (im != 0) ? sx(mode, b, k, 0) : -sx(mode, b, k, 1);
    endfunction

    task automatic run_stream(input int mode, input int nb);
        int sent;
        int rx;
        sent = 0;
        rx   = 0;
        for (int c = 0; c < 40 && rx < nb; c++) begin
            iREADY  = (mode == 0) ? !(c >= 5 && c < 9) : 1'b1;
            iVALID  = (sent < nb);
            iLAST   = (sent == nb - 1);
            iBYPASS = (mode == 1) && ((sent % 2) == 0);
            for (int k = 0; k < L; k++) begin
                set_lane(k, sx(mode, sent, k, 0), sx(mode, sent, k, 1),
                         (mode == 0) ? 1024 : 0, (mode == 0) ? 0 : 1024);
            end
            #1;
            if (!iREADY && a_oVALID) begin
                chk("stall_oready", a_oREADY, 1'b0);
                chk("stall_hold", lane(a_oY_RE, 0), ey(mode, rx, 0, 0));
            end
            if (a_oVALID && iREADY) begin
                for (int k = 0; k < L; k++) begin
                    chk($sformatf("m%0d_b%0d_l%0d_re", mode, rx, k), lane(a_oY_RE, k), ey(mode, rx, k, 0));
                    chk($sformatf("m%0d_b%0d_l%0d_im", mode, rx, k), lane(a_oY_IM, k), ey(mode, rx, k, 1));
                end
                chk($sformatf("m%0d_b%0d_last", mode, rx), a_oLAST, (rx == nb - 1));
                rx++;
            end
            if (iVALID && a_oREADY) sent++;
            tick();
        end
        iVALID  = 1'b0;
        iLAST   = 1'b0;
        iBYPASS = 1'b0;
        iREADY  = 1'b1;
        chk($sformatf("m%0d_beats_out", mode), rx, nb);
    endtask

    task automatic identity_lanes();
        set_lane(0, 7, -7, 0, 0);
        set_lane(1, 1000, -500, 1024, 0);
        set_lane(2, 1000, -500, 0, 1024);
        set_lane(3, 100, 200, 1024, 0);
    endtask

    initial begin
        iRESET = 1'b0; iVALID = 1'b0; iLAST = 1'b0; iBYPASS = 1'b0;
        iREADY = 1'b1; iCLR_SAT = 1'b0;
        iX_RE = '0; iX_IM = '0; iW_RE = '0; iW_IM = '0;

        // Reset state
        tick(); tick();
        chk("rst_ovalid", a_oVALID, 1'b0);
        chk("rst_olast", a_oLAST, 1'b0);
        chk("rst_osat", a_oSAT, 1'b0);
        chk("rst_oy_re", a_oY_RE[31:0], 32'd0);
        chk("rst_oy_im", a_oY_IM[31:0], 32'd0);
        chk("rst_b_ovalid", b_oVALID, 1'b0);
        iRESET = 1'b1;
        tick();

        // Identity and rotation
        identity_lanes();
        #1;
        chk("idle_oready", a_oREADY, 1'b1);
        send_one();
        chk("id_l0_re", lane(a_oY_RE, 0), 7);
        chk("id_l0_im", lane(a_oY_IM, 0), -7);
        chk("id_l1_re", lane(a_oY_RE, 1), 1000);
        chk("id_l1_im", lane(a_oY_IM, 1), -500);
        chk("id_l2_re", lane(a_oY_RE, 2), 500);
        chk("id_l2_im", lane(a_oY_IM, 2), 1000);
        chk("id_l3_re", lane(a_oY_RE, 3), 100);
        chk("id_l3_im", lane(a_oY_IM, 3), 200);
        chk("id_b_l1_im", lane(b_oY_IM, 1), -500);
        chk("id_b_l2_re", lane(b_oY_RE, 2), 500);
        chk("id_osat", a_oSAT, 1'b0);
        tick();
        chk("id_single_beat", a_oVALID, 1'b0);

        // Rounding and saturation
        set_lane(0, 7, -7, 0, 0);
        set_lane(1, 3, 0, 512, 0);
        set_lane(2, -3, 0, 512, 0);
        set_lane(3, -65536, 0, 0, -1024);
        send_one();
        chk("rnd1_pos", lane(a_oY_RE, 1), 2);
        chk("rnd0_pos", lane(b_oY_RE, 1), 1);
        chk("rnd1_neg", lane(a_oY_RE, 2), -1);
        chk("rnd0_neg", lane(b_oY_RE, 2), -2);
        chk("sat_im", lane(a_oY_IM, 3), 65535);
        chk("sat_re", lane(a_oY_RE, 3), 0);
        chk("wrap_im", lane(b_oY_IM, 3), -65536);
        chk("sat_l0_re", lane(a_oY_RE, 0), 7);
        chk("osat_set", a_oSAT, 1'b1);
        chk("osat_wrap_off", b_oSAT, 1'b0);
        tick();
        chk("osat_sticky", a_oSAT, 1'b1);
        iCLR_SAT = 1'b1;
        tick();
        chk("osat_clear", a_oSAT, 1'b0);

        // Saturation event wins over a simultaneous clear
        send_one();
        chk("osat_set_wins", a_oSAT, 1'b1);
        tick();
        chk("osat_clear2", a_oSAT, 1'b0);
        iCLR_SAT = 1'b0;

        // Backpressure and bypass streams
        run_stream(0, 8);
        tick();
        run_stream(1, 4);
        tick();

        // Reset mid-stream
        identity_lanes();
        set_lane(3, -65536, 0, 0, -1024);
        iLAST  = 1'b1;
        iVALID = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_ovalid", a_oVALID, 1'b1);
        chk("pre_rst_osat", a_oSAT, 1'b1);
        iVALID = 1'b0;
        iLAST  = 1'b0;
        iRESET = 1'b0;
        #1;
        chk("mid_rst_ovalid", a_oVALID, 1'b0);
        chk("mid_rst_olast", a_oLAST, 1'b0);
        chk("mid_rst_osat", a_oSAT, 1'b0);
        chk("mid_rst_oy_re", lane(a_oY_RE, 1), 0);
        chk("mid_rst_oy_im", lane(a_oY_IM, 3), 0);
        tick();
        iRESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst_no_stale_%0d", i), a_oVALID, 1'b0);
        end
        identity_lanes();
        send_one();
        chk("post_rst_l1_re", lane(a_oY_RE, 1), 1000);
        chk("post_rst_l3_im", lane(a_oY_IM, 3), 200);
        chk("post_rst_olast", a_oLAST, 1'b0);
        chk("post_rst_osat", a_oSAT, 1'b0);
        tick();
        chk("post_rst_single", a_oVALID, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
